// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// master clock frequency and the bit-period constants for common baud rates.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int UART_CLK_HZ         = 12_000_000;
    localparam int CLKS_PER_BIT_19200  = 625;
    localparam int CLKS_PER_BIT_115200 = 104;

    // Bit period in master-clock cycles for a given baud rate (truncating).
    function automatic int clks_per_bit(input int baud);
        return UART_CLK_HZ / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Both stages reset
// to 1 so the receiver sees an idle line while and right after reset.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw line through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first, idle-high line. Bytes are presented on a
// valid/ready handshake; framing errors and overruns are one-cycle pulses.
// CLKS_PER_BIT must be at least 8.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    // Start bit is checked half a period in, so every later sample lands
    // mid-bit after whole-period steps.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic              w_rxs;
    uart_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxs)
    );

    // Receive FSM with bit timing, shift register and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer takes the byte; a delivery below in the same cycle
            // overrides this clear.
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= START;
                    end
                end

                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        // A line back high at mid-start was only a glitch.
                        r_state   <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rxs;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // Return to IDLE at mid-stop so a back-to-back
                            // start edge is not missed.
                            r_state <= IDLE;
                            if (!r_valid || ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                BREAK: begin
                    // Hold here until the line idles so a stuck-low line
                    // does not look like an endless stream of start bits.
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 104 clocks per bit. Expected bytes, flags and
// delivery latencies are hand-derived from the bit timing.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int N   = 104;
    localparam int H   = N / 2 - 1;
    // Pin falling edge to valid: 2 sync + 1 IDLE->START + H+1 start + 9 bit periods.
    localparam int LAT = 4 + H + 9 * N;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rxd   = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] acc_data [0:63];
    int         acc_cyc  [0:63];
    int         acc_n  = 0;
    int         fe_n   = 0;
    int         fe_cyc = 0;
    int         ov_n   = 0;
    int         ov_cyc = 0;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log accepted bytes and flag pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready && acc_n < 64) begin
                acc_data[acc_n] <= data;
                acc_cyc[acc_n]  <= cyc;
                acc_n           <= acc_n + 1;
            end
            if (frame_err) begin
                fe_n   <= fe_n + 1;
                fe_cyc <= cyc;
            end
            if (overrun) begin
                ov_n   <= ov_n + 1;
                ov_cyc <= cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        step(N);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    int t0, t1, a0, f0, o0;

    initial begin
        // Reset state
        step(3);
        chk("rst_data",  32'(data), 32'h00);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ovr",   32'(overrun), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        step(5);

        // Good frame 0x41
        a0 = acc_n; f0 = fe_n; o0 = ov_n; t0 = cyc;
        send_frame(8'h41, 1'b1);
        step(N);
        chk("good_count", 32'(acc_n - a0), 32'd1);
        chk("good_data",  32'(acc_data[a0]), 32'h41);
        chk("good_lat",   32'(acc_cyc[a0] - t0), 32'(LAT));
        chk("good_flags", 32'((fe_n - f0) + (ov_n - o0)), 32'd0);

        // Back-to-back 0x00, 0xFF
        a0 = acc_n; f0 = fe_n; o0 = ov_n; t0 = cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        step(N);
        chk("b2b_count", 32'(acc_n - a0), 32'd2);
        chk("b2b_data0", 32'(acc_data[a0]), 32'h00);
        chk("b2b_data1", 32'(acc_data[a0 + 1]), 32'hFF);
        chk("b2b_lat0",  32'(acc_cyc[a0] - t0), 32'(LAT));
        chk("b2b_gap",   32'(acc_cyc[a0 + 1] - acc_cyc[a0]), 32'(10 * N));
        chk("b2b_flags", 32'((fe_n - f0) + (ov_n - o0)), 32'd0);

        // Glitch: 20 low cycles, well short of the mid-start sample
        a0 = acc_n; f0 = fe_n; t0 = cyc;
        rxd = 1'b0;
        step(10);
        chk("glitch_in_start", 32'(dut.r_state), 32'(START));
        step(10);
        rxd = 1'b1;
        step(4 + H - 20);
        chk("glitch_idle", 32'(dut.r_state), 32'(IDLE));
        step(2 * N);
        chk("glitch_novalid", 32'(acc_n - a0), 32'd0);
        chk("glitch_noferr",  32'(fe_n - f0), 32'd0);

        // Framing error on 0x55, line held low, then 0x33
        a0 = acc_n; f0 = fe_n; o0 = ov_n; t0 = cyc;
        send_frame(8'h55, 1'b0);
        rxd = 1'b0;
        step(3 * N);
        chk("ferr_in_break", 32'(dut.r_state), 32'(BREAK));
        rxd = 1'b1;
        step(N);
        t1 = cyc;
        send_frame(8'h33, 1'b1);
        step(N);
        chk("ferr_count", 32'(fe_n - f0), 32'd1);
        chk("ferr_time",  32'(fe_cyc - t0), 32'(LAT));
        chk("ferr_deliv", 32'(acc_n - a0), 32'd1);
        chk("ferr_data",  32'(acc_data[a0]), 32'h33);
        chk("ferr_lat",   32'(acc_cyc[a0] - t1), 32'(LAT));
        chk("ferr_noovr", 32'(ov_n - o0), 32'd0);

        // Overrun: 0x12 then 0x34 with ready low
        ready = 1'b0;
        a0 = acc_n; f0 = fe_n; o0 = ov_n; t0 = cyc;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        step(N);
        chk("ovr_valid", 32'(valid), 32'd1);
        chk("ovr_data",  32'(data), 32'h12);
        chk("ovr_count", 32'(ov_n - o0), 32'd1);
        chk("ovr_time",  32'(ov_cyc - t0), 32'(10 * N + LAT));
        chk("ovr_noferr", 32'(fe_n - f0), 32'd0);
        ready = 1'b1;
        step(1);
        chk("ovr_clear", 32'(valid), 32'd0);
        chk("ovr_taken", 32'(acc_data[a0]), 32'h12);
        chk("ovr_ntaken", 32'(acc_n - a0), 32'd1);

        // Reset mid-frame of 0xA5 with a byte held on the output
        ready = 1'b0;
        send_frame(8'h77, 1'b1);
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_data",  32'(data), 32'h77);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rxd = 1'b0;
        step(N / 2);
        chk("mid_state", 32'(dut.r_state), 32'(DATA));
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        chk("mrst_data",  32'(data), 32'h00);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_state", 32'(dut.r_state), 32'(IDLE));
        step(3);
        rst = 1'b0;
        step(2 * N);
        chk("post_novalid", 32'(valid), 32'd0);
        ready = 1'b1;
        a0 = acc_n; t0 = cyc;
        send_frame(8'h5A, 1'b1);
        step(N);
        chk("post_count", 32'(acc_n - a0), 32'd1);
        chk("post_data",  32'(acc_data[a0]), 32'h5A);
        chk("post_lat",   32'(acc_cyc[a0] - t0), 32'(LAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, line idle high. It recovers bytes from the `rxd` pin and presents them on a valid/ready handshake. It is the receive-side counterpart of the board's raw serial transmitter and runs from the same 12 MHz master clock. It flags framing errors and overruns with one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 625: clock cycles per bit (12 MHz / 625 = 19200 bps; 104 gives 115200 bps). Minimum 8.
- `clk` input, 1 bit: master clock, rising-edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `rxd` input, 1 bit: serial line, asynchronous to `clk`.
- `data` output, 8 bits: received byte, stable while `valid`=1.
- `valid` output, 1 bit: `data` holds an unconsumed byte.
- `ready` input, 1 bit: consumer accepts `data` on a cycle where `valid`&`ready`.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit samples 0.
- `overrun` output, 1 bit: one-cycle pulse when a byte completes while `valid`=1 and `ready`=0.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1 (idle). All logic below uses the synchronized value `rxs`.
- One bit counter, width clog2(`CLKS_PER_BIT`). It clears on every state entry.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, state IDLE, counter 0, bit index 0.
- States:
  - IDLE: on `rxs`=0, go to START.
  - START: at counter = `CLKS_PER_BIT`/2 − 1 (311), sample `rxs`.
    - 1 = glitch: return to IDLE with no flags.
    - 0: go to DATA with bit index 0.
  - DATA: at counter = `CLKS_PER_BIT` − 1 (624), shift `rxs` into shift-register bit [index]. Index 0 is the LSB. After index 7, go to STOP.
  - STOP: at counter = 624, sample `rxs`.
    - 1: deliver the byte (see handshake), then go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- Handshake and delivery:
  - `valid`&`ready` on a cycle: `valid` clears the next cycle unless a new delivery happens in the same cycle.
  - Delivery with `valid`=0: load `data`, set `valid`=1.
  - Delivery in the same cycle as `valid`&`ready`: load the new byte, `valid` stays 1, no overrun.
  - Delivery with `valid`=1 and `ready`=0: keep the old `data`, drop the new byte, pulse `overrun`.
- `ready` is ignored while `valid`=0.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the receiver waits in IDLE. It must see the synchronized line go low before starting. If released while the line is low mid-byte, the first low seen starts a (possibly corrupt) frame; this is accepted.

## Timing
- Synchronizer latency: 2 cycles.
- START entered 1 cycle after `rxs` goes low.
- Sampling points, counted from the `rxs` falling edge:
  - Start-bit check: cycle 312.
  - Data bit n: cycle 312 + 625·(n+1).
  - Stop bit: cycle 312 + 5625 = 5937.
- `valid` and `frame_err` become visible 1 cycle after the stop sample. Total: 5940 ±1 cycles after the pin's falling edge.
- After a good stop bit, IDLE is re-entered at mid-stop-bit. A start edge arriving immediately after is caught, so back-to-back frames are supported with no extra idle time.
- All outputs are registered. No combinational path from `rxd` or `ready` to any output.

## Structure
- Package `uart_pkg`:
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - `UART_CLK_HZ` = 12_000_000.
  - Default `CLKS_PER_BIT` constants for 19200 (625) and 115200 (104).
- Sub-module `uart_sync2`: 2-flop synchronizer, reset value 1, instantiated on `rxd`.
- FSM, counter, shift register and handshake live in `uart_rx`. Target size is roughly 150–250 lines.

## Test plan
- Good frame: drive 0x41 ('A') at 625 cycles/bit with `ready`=1 → `valid` pulses once at ~5940 cycles with `data`=0x41; no flags.
- Back-to-back frames: 0x00 then 0xFF, no idle gap, `ready`=1 → two deliveries of 0x00 and 0xFF exactly 6250 cycles apart; no flags.
- Glitch rejection: hold `rxd` low for 100 cycles, then high → no `valid`, no `frame_err`, state back to IDLE by cycle 313.
- Framing error: 0x55 with stop bit 0, line held low 2000 more cycles, then 0x33 → one `frame_err` pulse; no `valid` for 0x55; 0x33 delivered correctly.
- Overrun: 0x12 then 0x34 with `ready`=0 → `overrun` pulses at the second stop sample; `data` stays 0x12. Raising `ready` clears `valid` the next cycle.
- Reset mid-frame: assert `rst` during data bit 3 of 0xA5 → outputs at reset values within the reset cycle; with the line idle after release, no `valid`; a following 0x5A is received correctly.
